game_ctrl: RTL and testbench

- Game-level sequencer that drives the round block.
- Holds the per-level configuration (interval, duration, molenum) and issues one-cycle round_start pulses.
- Counts hit_success pulses per round and overall, and advances level or decrements lives after each round.
- Sits between the top-level button/display logic and the round block; owns game start, game over and win.

---
 rtl/game_pkg.sv | 34 +++
 rtl/level_cfg.sv | 21 ++
 rtl/game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and the per-level configuration table for the game sequencer.
package game_pkg;

    localparam int unsigned TIME_W    = 27;
    localparam int unsigned SMALL_W   = 3;
    localparam int unsigned TBL_N     = 4;
    localparam int unsigned TBL_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_ACK,
        ST_RUN,
        ST_EVAL,
        ST_GAME_OVER,
        ST_WIN
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0]  interval;
        logic [TIME_W-1:0]  duration;
        logic [SMALL_W-1:0] molenum;
        logic [SMALL_W-1:0] req_hits;
    } level_cfg_t;

    // Index 0 (rightmost) is level 0.
    localparam logic [TBL_N-1:0][TIME_W-1:0] INTERVAL_TBL =
        {27'd20_000_000, 27'd30_000_000, 27'd40_000_000, 27'd50_000_000};
    localparam logic [TBL_N-1:0][TIME_W-1:0] DURATION_TBL =
        {27'd30_000_000, 27'd45_000_000, 27'd60_000_000, 27'd75_000_000};
    localparam logic [TBL_N-1:0][SMALL_W-1:0] MOLENUM_TBL  = {3'd6, 3'd5, 3'd4, 3'd3};
    localparam logic [TBL_N-1:0][SMALL_W-1:0] REQ_HITS_TBL = {3'd5, 3'd4, 3'd3, 3'd2};

endpackage

// File: rtl/level_cfg.sv
// Combinational level -> configuration lookup; levels past the table reuse the last entry.
module level_cfg
    import game_pkg::*;
(
    input  logic [SMALL_W-1:0] i_level,
    output level_cfg_t         o_cfg_c
);

    logic [TBL_IDX_W-1:0] w_idx;

    assign w_idx = (i_level >= SMALL_W'(TBL_N)) ? TBL_IDX_W'(TBL_N - 1)
                                                : i_level[TBL_IDX_W-1:0];

    always_comb begin
        o_cfg_c.interval = INTERVAL_TBL[w_idx];
        o_cfg_c.duration = DURATION_TBL[w_idx];
        o_cfg_c.molenum  = MOLENUM_TBL[w_idx];
        o_cfg_c.req_hits = REQ_HITS_TBL[w_idx];
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: paces rounds, counts hits, and tracks level, lives, score, win and game over.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned SCORE_W      = 10,
    parameter int unsigned PAUSE_CYCLES = 50_000_000,
    parameter int unsigned ACK_TIMEOUT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               hit_success,
    input  logic               round_over,
    output logic               round_start,
    output logic [TIME_W-1:0]  interval,
    output logic [TIME_W-1:0]  duration,
    output logic [SMALL_W-1:0] molenum,
    output logic [SMALL_W-1:0] level,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               game_win,
    output logic               busy
);

    localparam int unsigned CNT_W   = $clog2(PAUSE_CYCLES + 1);
    localparam int unsigned ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned LIVES_W = 2;

    localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [SMALL_W-1:0] LAST_LEVEL = SMALL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [ACK_W-1:0]     r_ack, w_ack_nxt;
    logic [SMALL_W-1:0]   r_level, w_level_nxt;
    logic [LIVES_W-1:0]   r_lives, w_lives_nxt;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic [SMALL_W-1:0]   r_hits, w_hits_nxt;
    logic                 r_round_start, w_round_start_nxt;
    logic                 r_game_over, w_game_over_nxt;
    logic                 r_game_win, w_game_win_nxt;
    logic                 r_busy, w_busy_nxt;
    level_cfg_t           r_cfg, w_cfg_c;

    level_cfg u_level_cfg (
        .i_level (r_level),
        .o_cfg_c (w_cfg_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_ack          <= '0;
            r_level        <= '0;
            r_lives        <= LIVES_INIT;
            r_score        <= '0;
            r_hits         <= '0;
            r_round_start  <= 1'b0;
            r_game_over    <= 1'b0;
            r_game_win     <= 1'b0;
            r_busy         <= 1'b0;
            r_cfg.interval <= INTERVAL_TBL[0];
            r_cfg.duration <= DURATION_TBL[0];
            r_cfg.molenum  <= MOLENUM_TBL[0];
            r_cfg.req_hits <= REQ_HITS_TBL[0];
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ack         <= w_ack_nxt;
            r_level       <= w_level_nxt;
            r_lives       <= w_lives_nxt;
            r_score       <= w_score_nxt;
            r_hits        <= w_hits_nxt;
            r_round_start <= w_round_start_nxt;
            r_game_over   <= w_game_over_nxt;
            r_game_win    <= w_game_win_nxt;
            r_busy        <= w_busy_nxt;
            r_cfg         <= w_cfg_c;
        end
    end

    // Next-state and next-register logic; status flags derive from the next state.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_ack_nxt         = r_ack;
        w_level_nxt       = r_level;
        w_lives_nxt       = r_lives;
        w_score_nxt       = r_score;
        w_hits_nxt        = r_hits;
        w_round_start_nxt = 1'b0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (start_btn) begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = PAUSE_LOAD;
                    w_level_nxt = '0;
                    w_lives_nxt = LIVES_INIT;
                    w_score_nxt = '0;
                    w_hits_nxt  = '0;
                end
            end
            ST_PAUSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (round_over) begin
                    w_round_start_nxt = 1'b1;
                    w_ack_nxt         = '0;
                    w_state_nxt       = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!round_over) begin
                    w_state_nxt = ST_RUN;
                end else if (r_ack == ACK_LAST) begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = PAUSE_LOAD;
                end else begin
                    w_ack_nxt = r_ack + ACK_W'(1);
                end
            end
            ST_RUN: begin
                // A hit coinciding with round_over rising still counts.
                if (hit_success) begin
                    if (r_hits != '1)  w_hits_nxt  = r_hits + SMALL_W'(1);
                    if (r_score != '1) w_score_nxt = r_score + SCORE_W'(1);
                end
                if (round_over) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                w_hits_nxt = '0;
                if (r_hits >= r_cfg.req_hits) begin
                    if (r_level == LAST_LEVEL) begin
                        w_state_nxt = ST_WIN;
                    end else begin
                        w_level_nxt = r_level + SMALL_W'(1);
                        w_cnt_nxt   = PAUSE_LOAD;
                        w_state_nxt = ST_PAUSE;
                    end
                end else if (r_lives > LIVES_W'(1)) begin
                    w_lives_nxt = r_lives - LIVES_W'(1);
                    w_cnt_nxt   = PAUSE_LOAD;
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_lives_nxt = '0;
                    w_state_nxt = ST_GAME_OVER;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_game_over_nxt = (w_state_nxt == ST_GAME_OVER);
        w_game_win_nxt  = (w_state_nxt == ST_WIN);
        w_busy_nxt      = !(w_state_nxt inside {ST_IDLE, ST_GAME_OVER, ST_WIN});
    end

    assign round_start = r_round_start;
    assign interval    = r_cfg.interval;
    assign duration    = r_cfg.duration;
    assign molenum     = r_cfg.molenum;
    assign level       = r_level;
    assign lives       = r_lives;
    assign score       = r_score;
    assign game_over   = r_game_over;
    assign game_win    = r_game_win;
    assign busy        = r_busy;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a small game model queues expected post-round state,
// which is popped and compared once the DUT has evaluated each round.
module tb_game_ctrl;

    logic        clk;
    logic        rst;
    logic        start_btn;
    logic        hit_success;
    logic        round_over;
    logic        round_start;
    logic [26:0] interval;
    logic [26:0] duration;
    logic [2:0]  molenum;
    logic [2:0]  level;
    logic [1:0]  lives;
    logic [9:0]  score;
    logic        game_over;
    logic        game_win;
    logic        busy;

    game_ctrl #(
        .NUM_LEVELS   (4),
        .INIT_LIVES   (3),
        .SCORE_W      (10),
        .PAUSE_CYCLES (4),
        .ACK_TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .hit_success (hit_success),
        .round_over  (round_over),
        .round_start (round_start),
        .interval    (interval),
        .duration    (duration),
        .molenum     (molenum),
        .level       (level),
        .lives       (lives),
        .score       (score),
        .game_over   (game_over),
        .game_win    (game_win),
        .busy        (busy)
    );

    localparam int EXP_INT [4] = '{50000000, 40000000, 30000000, 20000000};
    localparam int EXP_DUR [4] = '{75000000, 60000000, 45000000, 30000000};
    localparam int EXP_MOL [4] = '{3, 4, 5, 6};
    localparam int EXP_REQ [4] = '{2, 3, 4, 5};

    typedef struct {
        int level;
        int lives;
        int score;
        bit game_over;
        bit game_win;
        bit busy;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_level, m_lives, m_score;
    bit m_over, m_win;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_rs(output int t);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (round_start === 1'b1) found = 1'b1;
        end
        check("rs_seen", 64'(found), 64'd1);
        t = cyc;
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        m_level = 0;
        m_lives = 3;
        m_score = 0;
        m_over  = 1'b0;
        m_win   = 1'b0;
    endtask

    // Game model: applies one round's hits and queues the resulting visible state.
    task automatic model_round(input int hits);
        exp_t e;
        m_score = (m_score + hits > 1023) ? 1023 : m_score + hits;
        if (hits >= EXP_REQ[m_level]) begin
            if (m_level == 3) m_win = 1'b1;
            else              m_level++;
        end else if (m_lives > 1) begin
            m_lives--;
        end else begin
            m_lives = 0;
            m_over  = 1'b1;
        end
        e.level     = m_level;
        e.lives     = m_lives;
        e.score     = m_score;
        e.game_over = m_over;
        e.game_win  = m_win;
        e.busy      = !(m_over || m_win);
        sb_q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("level",     64'(level),     64'(e.level));
            check("lives",     64'(lives),     64'(e.lives));
            check("score",     64'(score),     64'(e.score));
            check("interval",  64'(interval),  64'(EXP_INT[e.level]));
            check("duration",  64'(duration),  64'(EXP_DUR[e.level]));
            check("molenum",   64'(molenum),   64'(EXP_MOL[e.level]));
            check("game_over", 64'(game_over), 64'(e.game_over));
            check("game_win",  64'(game_win),  64'(e.game_win));
            check("busy",      64'(busy),      64'(e.busy));
        end
    endtask

    // Called with round_start currently visible; plays the round block's side.
    task automatic play_round(input int hits, input bit same_cycle, input bit start_in_run);
        model_round(hits + (same_cycle ? 1 : 0));
        tick();
        check("rs_pulse", 64'(round_start), 64'd0);
        round_over = 1'b0;
        tick();
        for (int i = 0; i < hits; i++) begin
            hit_success = 1'b1;
            if (start_in_run && i == 0) start_btn = 1'b1;
            tick();
            hit_success = 1'b0;
            start_btn   = 1'b0;
            tick();
        end
        round_over  = 1'b1;
        hit_success = same_cycle;
        tick();
        hit_success = 1'b0;
        tick();
        tick();
        compare_pop();
    endtask

    initial begin
        int t0, t1, t2, n_rs;
        rst         = 1'b0;
        start_btn   = 1'b0;
        hit_success = 1'b0;
        round_over  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_level",    64'(level),       64'd0);
        check("rst_lives",    64'(lives),       64'd3);
        check("rst_score",    64'(score),       64'd0);
        check("rst_rs",       64'(round_start), 64'd0);
        check("rst_busy",     64'(busy),        64'd0);
        check("rst_over",     64'(game_over),   64'd0);
        check("rst_win",      64'(game_win),    64'd0);
        check("rst_interval", 64'(interval),    64'd50000000);
        check("rst_duration", 64'(duration),    64'd75000000);
        check("rst_molenum",  64'(molenum),     64'd3);
        rst = 1'b1;
        tick();

        // Winning game: 2,3,4,5 hits; round 2 has a pause hit, a same-cycle hit and start_btn in RUN
        start_game();
        t0 = cyc;
        check("busy_after_start", 64'(busy), 64'd1);
        wait_rs(t1);
        check("rs_latency", 64'(t1 - t0), 64'd4);
        play_round(2, 1'b0, 1'b0);
        hit_success = 1'b1;
        tick();
        hit_success = 1'b0;
        wait_rs(t1);
        play_round(2, 1'b1, 1'b1);
        wait_rs(t1);
        play_round(4, 1'b0, 1'b0);
        wait_rs(t1);
        play_round(5, 1'b0, 1'b0);
        n_rs = 0;
        repeat (12) begin
            tick();
            if (round_start === 1'b1) n_rs++;
        end
        check("no_rs_after_win", 64'(n_rs), 64'd0);

        // Asynchronous reset in the middle of a RUN
        start_game();
        wait_rs(t1);
        play_round(2, 1'b0, 1'b0);
        wait_rs(t1);
        tick();
        round_over = 1'b0;
        tick();
        hit_success = 1'b1;
        tick();
        hit_success = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_level",    64'(level),       64'd0);
        check("mid_rst_score",    64'(score),       64'd0);
        check("mid_rst_lives",    64'(lives),       64'd3);
        check("mid_rst_rs",       64'(round_start), 64'd0);
        check("mid_rst_busy",     64'(busy),        64'd0);
        check("mid_rst_interval", 64'(interval),    64'd50000000);
        round_over = 1'b1;
        #1;
        rst = 1'b1;
        tick();
        sb_q.delete();

        // Losing game: three empty rounds
        start_game();
        for (int r = 0; r < 3; r++) begin
            wait_rs(t1);
            play_round(0, 1'b0, 1'b0);
        end
        n_rs = 0;
        repeat (12) begin
            tick();
            if (round_start === 1'b1) n_rs++;
        end
        check("no_rs_after_over", 64'(n_rs), 64'd0);

        // round_over stuck high: ACK times out and the round is retried
        start_game();
        check("restart_lives", 64'(lives),     64'd3);
        check("restart_over",  64'(game_over), 64'd0);
        wait_rs(t1);
        wait_rs(t2);
        check("retry_gap",  64'(t2 - t1), 64'd8);
        check("retry_busy", 64'(busy),    64'd1);
        check("retry_level", 64'(level),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
